// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline sequencing controller:
//   - 2-bit controller state encodings
//   - packed bundle of per-stage enables/flushes and its canonical values
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_ERROR    = 2'd3;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    // Everything frozen: memory stall, watchdog error, reset.
    localparam pipe_ctrl_t CTRL_HOLD   = 7'b00000_00;
    // Normal flow.
    localparam pipe_ctrl_t CTRL_RUN    = 7'b11111_00;
    // Taken branch: PC redirects, the two younger stages are squashed.
    localparam pipe_ctrl_t CTRL_FLUSH  = 7'b11111_11;
    // Load-use: PC and IF/ID hold, a bubble enters ID/EX, older stages drain.
    localparam pipe_ctrl_t CTRL_BUBBLE = 7'b00111_01;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
//   Combinational load-use compare between the instruction in ID and a load
//   in EX. Register r0 is hard-wired to zero and never creates a hazard.
// Ports
//   id_rs1_addr/id_rs2_addr  source registers of the ID instruction
//   id_rs1_used/id_rs2_used  ID instruction actually reads that source
//   ex_mem_rd_en             EX instruction is a load
//   ex_reg_wr_en             EX instruction writes a register
//   ex_reg_wr_addr           destination register of the EX instruction
//   load_use                 ID must wait one cycle for the load result
// -----------------------------------------------------------------------------
module hazard_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic                      ex_mem_rd_en,
    input  logic                      ex_reg_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
    output logic                      load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1_addr == ex_reg_wr_addr);
    assign rs2_hit  = id_rs2_used && (id_rs2_addr == ex_reg_wr_addr);
    assign load_use = ex_mem_rd_en && ex_reg_wr_en && (ex_reg_wr_addr != '0)
                      && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Sequencing controller for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB
//   pipeline registers. Produces per-stage load enables and bubble flushes for
//   load-use hazards, taken branches and data-memory wait states, with a
//   watchdog that parks the pipe in ERROR if memory never answers.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   id_*                source operands of the instruction in ID
//   ex_*                load/write-back info of the instruction in EX
//   select_new_pc       taken branch/jump resolved
//   dmem_req, dmem_ack  MEM stage access active / completes this cycle
//   pc_en, *_en         PC and pipe register load enables
//   if_id_flush,
//   id_ex_flush         load an all-zero-control bubble into the register
//   mem_timeout         sticky watchdog error (cleared only by reset)
//   stall_cycles        saturating count of cycles with pc_en low
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 1,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic                      ex_mem_rd_en,
    input  logic                      ex_reg_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
    input  logic                      select_new_pc,
    input  logic                      dmem_req,
    input  logic                      dmem_ack,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      id_ex_en,
    output logic                      ex_mem_en,
    output logic                      mem_wb_en,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      mem_timeout,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    // Timer only needs to reach MEM_TIMEOUT-1; flush counter FLUSH_CYCLES-1.
    localparam int TMR_W  = (MEM_TIMEOUT  > 1) ? $clog2(MEM_TIMEOUT)  : 1;
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_nxt;
    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_nxt;
    logic              load_use;
    logic              mem_stall;
    pipe_ctrl_t        ctrl;

    hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .ex_mem_rd_en   (ex_mem_rd_en),
        .ex_reg_wr_en   (ex_reg_wr_en),
        .ex_reg_wr_addr (ex_reg_wr_addr),
        .load_use       (load_use)
    );

    // The remaining flush count lives in fcnt rather than in the state alone,
    // so a memory stall that lands in the middle of a multi-cycle flush freezes
    // it and the flush resumes on the ack cycle.
    always_comb begin
        ctrl      = CTRL_HOLD;
        state_nxt = state;
        tmr_nxt   = tmr;
        fcnt_nxt  = fcnt;

        if (state == ST_MEM_WAIT) begin
            mem_stall = !dmem_ack;
        end else begin
            mem_stall = dmem_req && !dmem_ack;
        end

        if (state == ST_ERROR) begin
            ctrl = CTRL_HOLD;
        end else if (mem_stall) begin
            ctrl = CTRL_HOLD;
            if (state == ST_MEM_WAIT) begin
                if ((MEM_TIMEOUT != 0) && (tmr == TMR_W'(MEM_TIMEOUT - 1))) begin
                    state_nxt = ST_ERROR;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end else begin
                state_nxt = ST_MEM_WAIT;
                tmr_nxt   = '0;
            end
        end else begin
            tmr_nxt = '0;
            ctrl    = CTRL_RUN;
            if (select_new_pc) begin
                ctrl     = CTRL_FLUSH;
                fcnt_nxt = FCNT_W'(FLUSH_CYCLES - 1);
            end else if (fcnt != '0) begin
                ctrl     = CTRL_FLUSH;
                fcnt_nxt = fcnt - FCNT_W'(1);
            end else if (load_use) begin
                ctrl = CTRL_BUBBLE;
            end
            state_nxt = (fcnt_nxt != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            tmr   <= '0;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!ctrl.pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

    // Outputs are forced low while reset is held, independent of the state.
    assign pc_en       = rst_n && ctrl.pc_en;
    assign if_id_en    = rst_n && ctrl.if_id_en;
    assign id_ex_en    = rst_n && ctrl.id_ex_en;
    assign ex_mem_en   = rst_n && ctrl.ex_mem_en;
    assign mem_wb_en   = rst_n && ctrl.mem_wb_en;
    assign if_id_flush = rst_n && ctrl.if_id_flush;
    assign id_ex_flush = rst_n && ctrl.id_ex_flush;
    assign mem_timeout = (state == ST_ERROR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two controller instances share one stimulus stream:
//     inst 0: FLUSH_CYCLES=2, MEM_TIMEOUT=4, CNT_WIDTH=4
//     inst 1: defaults except MEM_TIMEOUT=0 (watchdog disabled)
//   A behavioural model runs beside them every cycle; table vectors and
//   hand-written sequences add fixed expectations for the named scenarios.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_reg_wr_addr;
    logic       id_rs1_used, id_rs2_used, ex_mem_rd_en, ex_reg_wr_en;
    logic       select_new_pc, dmem_req, dmem_ack;

    logic        pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0, if_id_flush0, id_ex_flush0, mem_timeout0;
    logic        pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_flush1, id_ex_flush1, mem_timeout1;
    logic [3:0]  stall0;
    logic [15:0] stall1;

    logic [6:0]  ctl [2];
    logic        to_a [2];
    int          stl_a [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_ADDR_WIDTH (5), .FLUSH_CYCLES (2), .MEM_TIMEOUT (4), .CNT_WIDTH (4)
    ) dut0 (
        .clk (clk), .rst_n (rst_n),
        .id_rs1_addr (id_rs1_addr), .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used), .id_rs2_used (id_rs2_used),
        .ex_mem_rd_en (ex_mem_rd_en), .ex_reg_wr_en (ex_reg_wr_en),
        .ex_reg_wr_addr (ex_reg_wr_addr), .select_new_pc (select_new_pc),
        .dmem_req (dmem_req), .dmem_ack (dmem_ack),
        .pc_en (pc_en0), .if_id_en (if_id_en0), .id_ex_en (id_ex_en0),
        .ex_mem_en (ex_mem_en0), .mem_wb_en (mem_wb_en0),
        .if_id_flush (if_id_flush0), .id_ex_flush (id_ex_flush0),
        .mem_timeout (mem_timeout0), .stall_cycles (stall0)
    );

    pipe_hazard_ctrl #(
        .REG_ADDR_WIDTH (5), .FLUSH_CYCLES (1), .MEM_TIMEOUT (0), .CNT_WIDTH (16)
    ) dut1 (
        .clk (clk), .rst_n (rst_n),
        .id_rs1_addr (id_rs1_addr), .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used), .id_rs2_used (id_rs2_used),
        .ex_mem_rd_en (ex_mem_rd_en), .ex_reg_wr_en (ex_reg_wr_en),
        .ex_reg_wr_addr (ex_reg_wr_addr), .select_new_pc (select_new_pc),
        .dmem_req (dmem_req), .dmem_ack (dmem_ack),
        .pc_en (pc_en1), .if_id_en (if_id_en1), .id_ex_en (id_ex_en1),
        .ex_mem_en (ex_mem_en1), .mem_wb_en (mem_wb_en1),
        .if_id_flush (if_id_flush1), .id_ex_flush (id_ex_flush1),
        .mem_timeout (mem_timeout1), .stall_cycles (stall1)
    );

    assign ctl[0]   = {pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0, if_id_flush0, id_ex_flush0};
    assign ctl[1]   = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_flush1, id_ex_flush1};
    assign to_a[0]  = mem_timeout0;
    assign to_a[1]  = mem_timeout1;
    assign stl_a[0] = int'(stall0);
    assign stl_a[1] = int'(stall1);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Expected control words, bit order {pc,if_id,id_ex,ex_mem,mem_wb,fl_if_id,fl_id_ex}
    localparam logic [6:0] E_HOLD = 7'b0000000;
    localparam logic [6:0] E_RUN  = 7'b1111100;
    localparam logic [6:0] E_BR   = 7'b1111111;
    localparam logic [6:0] E_LU   = 7'b0011101;

    typedef struct {
        bit err;    // watchdog fired
        bit wt;     // waiting on data memory
        int tmr;    // completed wait cycles
        int frem;   // flush cycles still owed after a branch
        int stl;    // cycles without PC advance
    } mdl_t;

    mdl_t m [2];
    mdl_t mn [2];
    int   FC_A [2]  = '{2, 1};
    int   TO_A [2]  = '{4, 0};
    int   MAX_A [2] = '{15, 65535};

    function automatic bit lu_ref();
        bit hit1, hit2;
        hit1 = id_rs1_used && (id_rs1_addr == ex_reg_wr_addr);
        hit2 = id_rs2_used && (id_rs2_addr == ex_reg_wr_addr);
        return ex_mem_rd_en && ex_reg_wr_en && (ex_reg_wr_addr != 0) && (hit1 || hit2);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mdl_t       s;
            bit         stalled;
            logic [6:0] e;
            s       = m[k];
            stalled = s.wt ? !dmem_ack : (dmem_req && !dmem_ack);
            if (!rst_n || s.err || stalled)         e = E_HOLD;
            else if (select_new_pc || s.frem > 0)   e = E_BR;
            else if (lu_ref())                      e = E_LU;
            else                                    e = E_RUN;
            chk($sformatf("model_ctrl[%0d]", k), 32'(ctl[k]), 32'(e));
            chk($sformatf("model_timeout[%0d]", k), 32'(to_a[k]), 32'(s.err));
            chk($sformatf("model_stall_cnt[%0d]", k), stl_a[k], s.stl);
            if (!rst_n) begin
                s = '{default: 0};
            end else begin
                if (e[6] == 1'b0) s.stl = (s.stl < MAX_A[k]) ? s.stl + 1 : s.stl;
                if (!s.err) begin
                    if (stalled) begin
                        if (!s.wt) begin
                            s.wt  = 1;
                            s.tmr = 0;
                        end else if (TO_A[k] != 0 && s.tmr == TO_A[k] - 1) begin
                            s.err = 1;
                        end else begin
                            s.tmr++;
                        end
                    end else begin
                        s.wt  = 0;
                        s.tmr = 0;
                        if (select_new_pc)    s.frem = FC_A[k] - 1;
                        else if (s.frem > 0)  s.frem--;
                    end
                end
            end
            mn[k] = s;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m[0] <= '{default: 0};
            m[1] <= '{default: 0};
        end else begin
            m[0] <= mn[0];
            m[1] <= mn[1];
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic clear_in();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_reg_wr_addr = '0;
        id_rs1_used = 0; id_rs2_used = 0; ex_mem_rd_en = 0; ex_reg_wr_en = 0;
        select_new_pc = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    // One reset cycle, ends at posedge+1 with rst_n released.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        @(negedge clk);
        chk("reset_ctrl", 32'(ctl[0]), 32'(E_HOLD));
        chk("reset_stall_cnt", 32'(stall0), 0);
        chk("reset_timeout", 32'(mem_timeout0), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Hand stimulus: load of r3 in EX with ID reading r3 when lu is set.
    task automatic drv(input bit sel, input bit req, input bit ack, input bit lu);
        clear_in();
        select_new_pc = sel;
        dmem_req      = req;
        dmem_ack      = ack;
        if (lu) begin
            ex_mem_rd_en = 1; ex_reg_wr_en = 1; ex_reg_wr_addr = 5'd3;
            id_rs1_addr  = 5'd3; id_rs1_used = 1;
        end
    endtask

    task automatic clk_chk(input string nm, input logic [6:0] exp, input bit exp_to);
        @(negedge clk);
        chk({nm, "_ctrl"}, 32'(ctl[0]), 32'(exp));
        chk({nm, "_timeout"}, 32'(mem_timeout0), 32'(exp_to));
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, ldr, wen;
        logic [4:0] wa;
        logic       sel, req, ack;
        logic [6:0] ctrl;
        int         stl;
    } vec_t;

    vec_t vt [12];

    initial begin
        clear_in();
        //        rs1    rs2    u1 u2 ldr wen wa     sel req ack  ctrl    stl
        vt[0]  = '{5'd3, 5'd0,  1, 0, 1,  1,  5'd3,  0,  0,  0,   E_LU,   1};
        vt[1]  = '{5'd0, 5'd0,  1, 0, 1,  1,  5'd0,  0,  0,  0,   E_RUN,  0};
        vt[2]  = '{5'd1, 5'd7,  1, 1, 1,  1,  5'd7,  0,  0,  0,   E_LU,   1};
        vt[3]  = '{5'd7, 5'd2,  0, 1, 1,  1,  5'd7,  0,  0,  0,   E_RUN,  0};
        vt[4]  = '{5'd5, 5'd0,  1, 0, 1,  0,  5'd5,  0,  0,  0,   E_RUN,  0};
        vt[5]  = '{5'd5, 5'd0,  1, 0, 0,  1,  5'd5,  0,  0,  0,   E_RUN,  0};
        vt[6]  = '{5'd0, 5'd0,  0, 0, 0,  0,  5'd0,  0,  1,  1,   E_RUN,  0};
        vt[7]  = '{5'd0, 5'd0,  0, 0, 0,  0,  5'd0,  0,  1,  0,   E_HOLD, 1};
        vt[8]  = '{5'd0, 5'd0,  0, 0, 0,  0,  5'd0,  1,  0,  0,   E_BR,   0};
        vt[9]  = '{5'd3, 5'd0,  1, 0, 1,  1,  5'd3,  1,  0,  0,   E_BR,   0};
        vt[10] = '{5'd3, 5'd0,  1, 0, 1,  1,  5'd3,  1,  1,  0,   E_HOLD, 1};
        vt[11] = '{5'd31,5'd31, 0, 1, 1,  1,  5'd31, 0,  1,  1,   E_LU,   1};

        #1 rst_n = 1'b0;
        do_reset();

        foreach (vt[i]) begin
            do_reset();
            id_rs1_addr = vt[i].rs1; id_rs2_addr = vt[i].rs2;
            id_rs1_used = vt[i].u1;  id_rs2_used = vt[i].u2;
            ex_mem_rd_en = vt[i].ldr; ex_reg_wr_en = vt[i].wen; ex_reg_wr_addr = vt[i].wa;
            select_new_pc = vt[i].sel; dmem_req = vt[i].req; dmem_ack = vt[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d_ctrl", i), 32'(ctl[0]), 32'(vt[i].ctrl));
            chk($sformatf("vec%0d_ctrl_inst1", i), 32'(ctl[1]), 32'(vt[i].ctrl));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_stall_cnt", i), 32'(stall0), 32'(vt[i].stl));
        end

        // Memory wait: ack on the fourth cycle -> three frozen cycles.
        do_reset();
        drv(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) clk_chk("memwait_frozen", E_HOLD, 0);
        drv(0, 1, 1, 0);
        clk_chk("memwait_ack", E_RUN, 0);
        chk("memwait_stall_cnt", 32'(stall0), 3);

        // Branch with two flush cycles.
        do_reset();
        drv(1, 0, 0, 0);
        clk_chk("branch_c1", E_BR, 0);
        drv(0, 0, 0, 0);
        clk_chk("branch_c2", E_BR, 0);
        clk_chk("branch_c3", E_RUN, 0);

        // Branch + load-use + memory stall: freeze, then flush, no bubble.
        do_reset();
        drv(1, 1, 0, 1);
        clk_chk("combo_frozen1", E_HOLD, 0);
        clk_chk("combo_frozen2", E_HOLD, 0);
        drv(1, 1, 1, 1);
        clk_chk("combo_ack_flush", E_BR, 0);
        drv(0, 0, 0, 0);
        clk_chk("combo_flush2", E_BR, 0);
        clk_chk("combo_run", E_RUN, 0);
        chk("combo_stall_cnt", 32'(stall0), 2);

        // Watchdog: entry cycle + 4 wait cycles, then sticky ERROR.
        do_reset();
        drv(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) clk_chk("wdog_wait", E_HOLD, 0);
        clk_chk("wdog_error", E_HOLD, 1);
        drv(0, 1, 1, 0);
        clk_chk("wdog_sticky", E_HOLD, 1);
        chk("wdog_disabled_inst1", 32'(mem_timeout1), 0);
        drv(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) clk_chk("wdog_hold", E_HOLD, 1);
        chk("stall_cnt_saturated", 32'(stall0), 15);
        do_reset();
        @(negedge clk);
        chk("wdog_cleared", 32'(mem_timeout0), 0);
        @(posedge clk);
        #1;

        // Randomized traffic, model-checked every cycle.
        for (int c = 0; c < 4000; c++) begin
            rst_n          = ($urandom_range(199) != 0);
            id_rs1_addr    = 5'($urandom_range(3));
            id_rs2_addr    = 5'($urandom_range(3));
            ex_reg_wr_addr = 5'($urandom_range(3));
            id_rs1_used    = 1'($urandom_range(1));
            id_rs2_used    = 1'($urandom_range(1));
            ex_mem_rd_en   = 1'($urandom_range(1));
            ex_reg_wr_en   = ($urandom_range(3) != 0);
            select_new_pc  = ($urandom_range(7) == 0);
            dmem_req       = ($urandom_range(3) == 0);
            dmem_ack       = ($urandom_range(2) == 0);
            @(posedge clk);
            #1;
        end

        rst_n = 1'b1;
        clear_in();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
